// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM scan-out / CPU arbiter.
package vram_arb_pkg;

  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_WORDS_PER_LINE  = 160;
  localparam int DEF_LB_ADDR_WIDTH   = 8;
  localparam int DEF_LINE_WIDTH      = 10;
  localparam int DEF_FB_BASE         = 0;
  localparam int DEF_CPU_SLOT_PERIOD = 4;

  // Owner of the VRAM access issued last cycle, i.e. of the data now on in_mem_rdata.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_FETCH = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_CPU   = 2'd1,
    GNT_FETCH = 2'd2
  } grant_e;

endpackage

// File: rtl/vram_scan_arbiter_line_fetch_counter.sv
// Line fetch sequencer: latches the requested line, walks the word index and
// produces the VRAM address; a new line_start while busy aborts and restarts.
module line_fetch_counter #(
  parameter int AW      = 16,
  parameter int LBW     = 8,
  parameter int LW      = 10,
  parameter int WPL     = 160,
  parameter int FB_BASE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           line_start,
  input  logic [LW-1:0]  next_line,
  input  logic           advance,
  output logic           busy,
  output logic           busy_next,
  output logic [LBW-1:0] idx,
  output logic [AW-1:0]  addr,
  output logic           bank,
  output logic           abort
);

  localparam logic [LBW-1:0] LAST_IDX = LBW'(WPL - 1);

  logic [LW-1:0]  line_q, line_d;
  logic [LBW-1:0] idx_q, idx_d;
  logic           busy_q, busy_d;

  always_comb begin
    line_d = line_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    // A restart wins over an advance of the old line in the same cycle.
    if (line_start) begin
      line_d = next_line;
      idx_d  = '0;
      busy_d = 1'b1;
    end else if (advance && busy_q) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      line_q <= line_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign busy_next = busy_d;
  assign idx       = idx_q;
  assign addr      = AW'(FB_BASE) + AW'(line_q) * AW'(WPL) + AW'(idx_q);
  assign bank      = line_q[0];
  assign abort     = line_start & busy_q;

endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter between scan-out line prefetch and a CPU port.
// Optional VRAM_ARB_UNDERRUN_EN adds sticky underrun flag and saturating abort counter.
module vram_scan_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int LB_ADDR_WIDTH   = DEF_LB_ADDR_WIDTH,
  parameter int LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter int FB_BASE         = DEF_FB_BASE,
  parameter int CPU_SLOT_PERIOD = DEF_CPU_SLOT_PERIOD
) (
  input  logic                     clk_pixel,
  input  logic                     rst_n,
  input  logic                     in_line_start,
  input  logic [LINE_WIDTH-1:0]    in_next_line,
  input  logic                     in_cpu_req,
  input  logic                     in_cpu_we,
  input  logic [ADDR_WIDTH-1:0]    in_cpu_addr,
  input  logic [DATA_WIDTH-1:0]    in_cpu_wdata,
  output logic                     out_cpu_ack,
  output logic [DATA_WIDTH-1:0]    out_cpu_rdata,
  output logic [ADDR_WIDTH-1:0]    out_mem_addr,
  output logic                     out_mem_we,
  output logic [DATA_WIDTH-1:0]    out_mem_wdata,
  input  logic [DATA_WIDTH-1:0]    in_mem_rdata,
  output logic                     out_lb_wr_en,
  output logic                     out_lb_bank,
  output logic [LB_ADDR_WIDTH-1:0] out_lb_wr_addr,
  output logic [DATA_WIDTH-1:0]    out_lb_wr_data,
  output logic                     out_fetch_busy
`ifdef VRAM_ARB_UNDERRUN_EN
  ,
  output logic                     out_underrun,
  output logic [7:0]               out_underrun_count
`endif
);

  localparam int SLOT_W = $clog2(CPU_SLOT_PERIOD);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CPU_SLOT_PERIOD - 1);

  logic                     fetch_busy, fetch_busy_next, fetch_bank, fetch_abort;
  logic [LB_ADDR_WIDTH-1:0] fetch_idx;
  logic [ADDR_WIDTH-1:0]    fetch_addr;
  grant_e                   grant;
  logic                     cpu_eligible;

  owner_e                   tag_owner_q, tag_owner_d;
  logic [LB_ADDR_WIDTH-1:0] tag_idx_q, tag_idx_d;
  logic                     tag_bank_q, tag_bank_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;

  line_fetch_counter #(
    .AW      (ADDR_WIDTH),
    .LBW     (LB_ADDR_WIDTH),
    .LW      (LINE_WIDTH),
    .WPL     (WORDS_PER_LINE),
    .FB_BASE (FB_BASE)
  ) u_fetch (
    .clk        (clk_pixel),
    .rst_n      (rst_n),
    .line_start (in_line_start),
    .next_line  (in_next_line),
    .advance    (grant == GNT_FETCH),
    .busy       (fetch_busy),
    .busy_next  (fetch_busy_next),
    .idx        (fetch_idx),
    .addr       (fetch_addr),
    .bank       (fetch_bank),
    .abort      (fetch_abort)
  );

  // A CPU access still returning data blocks a new grant: one bubble per transaction.
  assign cpu_eligible = in_cpu_req && (tag_owner_q != OWN_CPU);

  always_comb begin
    grant = GNT_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (fetch_busy) begin
      grant = (slot_q == SLOT_LAST && cpu_eligible) ? GNT_CPU : GNT_FETCH;
    end else if (cpu_eligible) begin
      grant = GNT_CPU;
    end
  end

  always_comb begin
    out_mem_addr  = '0;
    out_mem_we    = 1'b0;
    out_mem_wdata = '0;
    tag_owner_d   = OWN_NONE;
    tag_idx_d     = '0;
    tag_bank_d    = 1'b0;
    case (grant)
      GNT_CPU: begin
        out_mem_addr  = in_cpu_addr;
        out_mem_we    = in_cpu_we;
        out_mem_wdata = in_cpu_wdata;
        tag_owner_d   = OWN_CPU;
      end
      GNT_FETCH: begin
        out_mem_addr = fetch_addr;
        tag_owner_d  = OWN_FETCH;
        tag_idx_d    = fetch_idx;
        tag_bank_d   = fetch_bank;
      end
      default: ;
    endcase
    // Slot counter only runs while a fetch stays active into the next cycle.
    slot_d = '0;
    if (fetch_busy && fetch_busy_next)
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      tag_owner_q <= OWN_NONE;
      tag_idx_q   <= '0;
      tag_bank_q  <= 1'b0;
      slot_q      <= '0;
    end else begin
      tag_owner_q <= tag_owner_d;
      tag_idx_q   <= tag_idx_d;
      tag_bank_q  <= tag_bank_d;
      slot_q      <= slot_d;
    end
  end

  assign out_cpu_ack    = rst_n && (tag_owner_q == OWN_CPU);
  assign out_cpu_rdata  = out_cpu_ack ? in_mem_rdata : '0;
  assign out_lb_wr_en   = rst_n && (tag_owner_q == OWN_FETCH);
  assign out_lb_bank    = out_lb_wr_en & tag_bank_q;
  assign out_lb_wr_addr = out_lb_wr_en ? tag_idx_q : '0;
  assign out_lb_wr_data = out_lb_wr_en ? in_mem_rdata : '0;
  assign out_fetch_busy = fetch_busy;

`ifdef VRAM_ARB_UNDERRUN_EN
  logic       underrun_q, underrun_d;
  logic [7:0] underrun_count_q, underrun_count_d;

  always_comb begin
    underrun_d       = underrun_q;
    underrun_count_d = underrun_count_q;
    if (in_line_start && in_next_line == '0) underrun_d = 1'b0;
    if (fetch_abort) begin
      underrun_d = 1'b1;
      if (underrun_count_q != 8'hFF) underrun_count_d = underrun_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign out_underrun       = underrun_q;
  assign out_underrun_count = underrun_count_q;
`else
  logic unused_abort;
  assign unused_abort = fetch_abort;
`endif

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Scoreboard bench for vram_scan_arbiter: directed CPU and line-fetch scenarios
// against a registered-read VRAM model; queues hold expected CPU and line-buffer traffic.
module tb_vram_scan_arbiter;

  logic        clk_pixel;
  logic        rst_n;
  logic        in_line_start;
  logic [9:0]  in_next_line;
  logic        in_cpu_req;
  logic        in_cpu_we;
  logic [15:0] in_cpu_addr;
  logic [15:0] in_cpu_wdata;
  logic        out_cpu_ack;
  logic [15:0] out_cpu_rdata;
  logic [15:0] out_mem_addr;
  logic        out_mem_we;
  logic [15:0] out_mem_wdata;
  logic [15:0] in_mem_rdata;
  logic        out_lb_wr_en;
  logic        out_lb_bank;
  logic [7:0]  out_lb_wr_addr;
  logic [15:0] out_lb_wr_data;
  logic        out_fetch_busy;
`ifdef VRAM_ARB_UNDERRUN_EN
  logic        out_underrun;
  logic [7:0]  out_underrun_count;
`endif

  vram_scan_arbiter dut (
    .clk_pixel      (clk_pixel),
    .rst_n          (rst_n),
    .in_line_start  (in_line_start),
    .in_next_line   (in_next_line),
    .in_cpu_req     (in_cpu_req),
    .in_cpu_we      (in_cpu_we),
    .in_cpu_addr    (in_cpu_addr),
    .in_cpu_wdata   (in_cpu_wdata),
    .out_cpu_ack    (out_cpu_ack),
    .out_cpu_rdata  (out_cpu_rdata),
    .out_mem_addr   (out_mem_addr),
    .out_mem_we     (out_mem_we),
    .out_mem_wdata  (out_mem_wdata),
    .in_mem_rdata   (in_mem_rdata),
    .out_lb_wr_en   (out_lb_wr_en),
    .out_lb_bank    (out_lb_bank),
    .out_lb_wr_addr (out_lb_wr_addr),
    .out_lb_wr_data (out_lb_wr_data),
    .out_fetch_busy (out_fetch_busy)
`ifdef VRAM_ARB_UNDERRUN_EN
    ,
    .out_underrun       (out_underrun),
    .out_underrun_count (out_underrun_count)
`endif
  );

  // ---------------- clock / reset / VRAM model ----------------
  initial clk_pixel = 1'b0;
  always #20 clk_pixel = ~clk_pixel;

  logic [15:0] vram [0:65535];

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ 16'hC35A;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) vram[i] = pat(i);
  end

  always @(posedge clk_pixel) begin
    in_mem_rdata <= vram[out_mem_addr];
    if (out_mem_we) vram[out_mem_addr] <= out_mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int back2back = 0;
  logic prev_ack = 1'b0;
  logic [16:0] cpu_exp_q[$];   // {is_read, rdata}
  logic [24:0] lb_exp_q[$];    // {bank, idx, data}
  logic [15:0] exp_over [int];
  logic [16:0] cpu_e;
  logic [24:0] lb_e;

  function automatic logic [15:0] exp_word(input int a);
    return exp_over.exists(a) ? exp_over[a] : pat(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_pixel) begin
    if (out_cpu_ack) begin
      if (prev_ack) back2back++;
      checks++;
      if (cpu_exp_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_ack_unexpected: got ack expected none at %0t", $time);
      end else begin
        cpu_e = cpu_exp_q.pop_front();
        if (cpu_e[16] && out_cpu_rdata !== cpu_e[15:0]) begin
          errors++;
          $display("FAIL cpu_rdata: got %h expected %h at %0t", out_cpu_rdata, cpu_e[15:0], $time);
        end
      end
    end
    prev_ack = out_cpu_ack;
    if (out_lb_wr_en) begin
      checks++;
      if (lb_exp_q.size() == 0) begin
        errors++;
        $display("FAIL lb_write_unexpected: got bank %0d idx %0d data %h expected none at %0t",
                 out_lb_bank, out_lb_wr_addr, out_lb_wr_data, $time);
      end else begin
        lb_e = lb_exp_q.pop_front();
        if ({out_lb_bank, out_lb_wr_addr, out_lb_wr_data} !== lb_e) begin
          errors++;
          $display("FAIL lb_write: got bank %0d idx %0d data %h expected bank %0d idx %0d data %h at %0t",
                   out_lb_bank, out_lb_wr_addr, out_lb_wr_data, lb_e[24], lb_e[23:16], lb_e[15:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_line(input int line, input int n);
    for (int i = 0; i < n; i++)
      lb_exp_q.push_back({1'(line & 1), 8'(i), exp_word((line * 160 + i) & 16'hFFFF)});
  endtask

  task automatic cpu_issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    in_cpu_req   = 1'b1;
    in_cpu_we    = we;
    in_cpu_addr  = addr;
    in_cpu_wdata = wdata;
    cpu_exp_q.push_back({~we, we ? 16'h0000 : exp_word(int'(addr))});
    if (we) exp_over[int'(addr)] = wdata;
  endtask

  task automatic cpu_wait(output int n);
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!out_cpu_ack && n < 50);
    if (!out_cpu_ack) begin
      checks++;
      errors++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack within 50 cycles");
    end
    @(posedge clk_pixel); #1;
    in_cpu_req = 1'b0;
  endtask

  task automatic start_line(input int line);
    in_line_start = 1'b1;
    in_next_line  = 10'(line);
    @(posedge clk_pixel); #1;
    in_line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (out_fetch_busy && n < 600);
    check(name, 64'(out_fetch_busy), 64'd0);
    @(posedge clk_pixel); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_cpu"}, {out_cpu_ack, out_cpu_rdata}, 64'd0);
    check({name, "_mem"}, {out_mem_we, out_mem_addr, out_mem_wdata}, 64'd0);
    check({name, "_lb"}, {out_lb_wr_en, out_lb_bank, out_lb_wr_addr, out_lb_wr_data, out_fetch_busy}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  int n, busy_cnt, ack_cnt, lb_cnt;
  logic t3_stop, found;

  initial begin
    rst_n = 1'b0;
    in_line_start = 1'b0;
    in_next_line = '0;
    in_cpu_req = 1'b0;
    in_cpu_we = 1'b0;
    in_cpu_addr = '0;
    in_cpu_wdata = '0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_outputs_zero("t1_reset");
    @(posedge clk_pixel); #1;
    rst_n = 1'b1;
    @(posedge clk_pixel); #1;
    check_outputs_zero("t1_idle");

    // 1: idle CPU read of 0x0010 -> 0x0010 ^ 0xC35A = 0xC34A
    cpu_issue(1'b0, 16'h0010, 16'h0000);
    @(negedge clk_pixel);
    check("t1_mem_addr", {out_mem_we, out_mem_addr}, {1'b0, 16'h0010});
    cpu_wait(n);
    check("t1_ack_latency", 64'(n), 64'd1);

    // 2: fetch line 5 with no CPU traffic: 0x0320..0x03BF into bank 1
    push_line(5, 160);
    start_line(5);
    for (int j = 0; j < 160; j++) begin
      @(negedge clk_pixel);
      check("t2_fetch_addr", {out_mem_we, out_mem_addr}, {1'b0, 16'(16'h0320 + j)});
    end
    check("t2_busy_last", 64'(out_fetch_busy), 64'd1);
    @(negedge clk_pixel);
    check("t2_busy_clear", 64'(out_fetch_busy), 64'd0);
    @(posedge clk_pixel); #1;
    repeat (2) @(posedge clk_pixel); #1;

    // 4: CPU write lands in the next fetch of line 5 at idx 1
    cpu_issue(1'b1, 16'h0321, 16'hBEEF);
    cpu_wait(n);
    push_line(5, 160);
    start_line(5);
    wait_idle("t4_fetch_done");
    cpu_issue(1'b0, 16'h0321, 16'h0000);
    cpu_wait(n);

    // 3: CPU req held through a fetch of line 7; 3 fetch + 1 CPU per 4 slots
    // -> 160 fetches take 213 busy cycles, with 54 CPU acks inside the window.
    push_line(7, 160);
    t3_stop = 1'b0;
    busy_cnt = 0;
    ack_cnt = 0;
    fork
      begin
        int k = 0;
        int m;
        while (!t3_stop) begin
          cpu_issue(1'b0, 16'(16'h4000 + k), 16'h0000);
          cpu_wait(m);
          k++;
        end
      end
      begin
        start_line(7);
        for (int c = 0; c < 600; c++) begin
          @(negedge clk_pixel);
          if (!out_fetch_busy) break;
          busy_cnt++;
          if (out_cpu_ack) ack_cnt++;
        end
        t3_stop = 1'b1;
      end
    join
    check("t3_busy_cycles", 64'(busy_cnt), 64'd213);
    check("t3_cpu_acks", 64'(ack_cnt), 64'd54);
    repeat (2) @(posedge clk_pixel); #1;

    // 5: restart 50 cycles in; old idx 49 still lands in bank 0
    push_line(2, 50);
    push_line(3, 160);
    start_line(2);
    repeat (49) @(posedge clk_pixel);
    #1;
    start_line(3);
    wait_idle("t5_fetch_done");
`ifdef VRAM_ARB_UNDERRUN_EN
    check("t5_underrun", 64'(out_underrun), 64'd1);
    check("t5_underrun_count", 64'(out_underrun_count), 64'd1);
    push_line(0, 160);
    start_line(0);
    wait_idle("t5_line0_done");
    check("t5_underrun_cleared", 64'(out_underrun), 64'd0);
    check("t5_count_kept", 64'(out_underrun_count), 64'd1);
`endif

    // 6: reset during fetch while a CPU read is in flight
    push_line(1, 160);
    start_line(1);
    repeat (10) @(posedge clk_pixel);
    #1;
    cpu_issue(1'b0, 16'h7000, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_pixel);
      if (out_mem_addr == 16'h7000 && !out_mem_we) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_cpu_grant", 64'(found), 64'd1);
    #1;
    rst_n = 1'b0;
    @(posedge clk_pixel); #1;
    in_cpu_req = 1'b0;
    cpu_exp_q.delete();
    lb_exp_q.delete();
    @(negedge clk_pixel);
    check_outputs_zero("t6_reset");
    ack_cnt = 0;
    lb_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) begin
        @(posedge clk_pixel); #1;
        rst_n = 1'b1;
      end
      @(negedge clk_pixel);
      if (out_cpu_ack) ack_cnt++;
      if (out_lb_wr_en || out_fetch_busy) lb_cnt++;
    end
    check("t6_no_ack", 64'(ack_cnt), 64'd0);
    check("t6_no_lb_or_busy", 64'(lb_cnt), 64'd0);

    check("end_cpu_queue_empty", 64'(cpu_exp_q.size()), 64'd0);
    check("end_lb_queue_empty", 64'(lb_exp_q.size()), 64'd0);
    check("end_ack_bubbles", 64'(back2back), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
